coreriscv_axi4_meta_arbiter: RTL and testbench

CORERISCV_AXI4_META_ARBITER -- requirements
Module: coreriscv_axi4_meta_arbiter

---
 rtl/coreriscv_axi4_meta_arbiter_pkg.sv | 44 ++++
 rtl/coreriscv_axi4_rr_grant.sv | 36 +++
 rtl/coreriscv_axi4_meta_arbiter.sv | 87 ++++++++
 tb/tb_coreriscv_axi4_meta_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coreriscv_axi4_meta_arbiter_pkg.sv
// Shared cache-metadata definitions for the AXI4 meta arbiter.
// Payload packing is {idx, way_en, tag, coh_state}, MSB to LSB.
package coreriscv_axi4_meta_arbiter_pkg;

  typedef enum logic {
    POL_FIXED = 1'b0,
    POL_RR    = 1'b1
  } arb_pol_e;

  function automatic int pay_width(
    int idx_w,
    int ways,
    int tag_w,
    int coh_w
  );
    return idx_w + ways + tag_w + coh_w;
  endfunction

  function automatic int ch_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Field LSB offsets inside a packed payload.
  function automatic int coh_lsb();
    return 0;
  endfunction

  function automatic int tag_lsb(int coh_w);
    return coh_w;
  endfunction

  function automatic int way_lsb(int coh_w, int tag_w);
    return coh_w + tag_w;
  endfunction

  function automatic int idx_lsb(
    int coh_w,
    int tag_w,
    int ways
  );
    return coh_w + tag_w + ways;
  endfunction

endpackage

// File: rtl/coreriscv_axi4_rr_grant.sv
// Grant selection: first valid at or after ptr (round-robin)
// or lowest valid index (fixed priority).
module coreriscv_axi4_rr_grant
  import coreriscv_axi4_meta_arbiter_pkg::*;
#(
  parameter int N    = 3,
  parameter int CH_W = 2
) (
  input  logic [N-1:0]    valid,
  input  logic [CH_W-1:0] ptr,
  input  arb_pol_e        mode,
  output logic [N-1:0]    grant,
  output logic [CH_W-1:0] idx
);

  int   base;
  int   j;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    base  = (mode == POL_RR) ? int'(ptr) : 0;
    for (int k = 0; k < N; k++) begin
      j = (base + k) % N;
      if (!found && valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = CH_W'(j);
      end
    end
  end

endmodule

// File: rtl/coreriscv_axi4_meta_arbiter.sv
// N-way cache-metadata arbiter with a one-entry registered
// output stage; round-robin or fixed-priority grant.
module coreriscv_axi4_meta_arbiter
  import coreriscv_axi4_meta_arbiter_pkg::*;
#(
  parameter  int N_IN    = 3,
  parameter  int IDX_W   = 7,
  parameter  int WAYS    = 1,
  parameter  int TAG_W   = 19,
  parameter  int COH_W   = 2,
  parameter  int RR_MODE = 1,
  localparam int PAY_W   =
    pay_width(IDX_W, WAYS, TAG_W, COH_W),
  localparam int CH_W    = ch_width(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN-1:0]       io_in_valid,
  output logic [N_IN-1:0]       io_in_ready,
  input  logic [N_IN*PAY_W-1:0] io_in_bits,
  output logic                  io_out_valid,
  input  logic                  io_out_ready,
  output logic [PAY_W-1:0]      io_out_bits,
  output logic [CH_W-1:0]       io_chosen
);

  localparam arb_pol_e MODE =
    (RR_MODE != 0) ? POL_RR : POL_FIXED;

  logic [CH_W-1:0]  ptr;
  logic [CH_W-1:0]  gidx;
  logic [CH_W-1:0]  ptr_nxt;
  logic [N_IN-1:0]  grant;
  logic [PAY_W-1:0] sel;
  logic             can_load;
  logic             xfer;

  coreriscv_axi4_rr_grant #(
    .N    (N_IN),
    .CH_W (CH_W)
  ) u_grant (
    .valid (io_in_valid),
    .ptr   (ptr),
    .mode  (MODE),
    .grant (grant),
    .idx   (gidx)
  );

  assign can_load = ~io_out_valid | io_out_ready;

  // Reset gating keeps requesters from handshaking while held in reset.
  assign io_in_ready =
    (reset & can_load) ? grant : '0;

  assign xfer = |(io_in_valid & io_in_ready);

  assign ptr_nxt =
    (gidx == CH_W'(N_IN - 1)) ? '0 : gidx + CH_W'(1);

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant[i]) begin
        sel = sel | io_in_bits[i*PAY_W +: PAY_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_out_valid <= 1'b0;
      io_out_bits  <= '0;
      io_chosen    <= '0;
      ptr          <= '0;
    end else if (xfer) begin
      io_out_valid <= 1'b1;
      io_out_bits  <= sel;
      io_chosen    <= gidx;
      if (MODE == POL_RR) begin
        ptr <= ptr_nxt;
      end
    end else if (io_out_ready) begin
      io_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_coreriscv_axi4_meta_arbiter.sv
// Directed checks of the meta arbiter in RR, fixed and 8-way
// configurations, followed by a scoreboarded random run.
module tb_coreriscv_axi4_meta_arbiter;

  localparam int PW = 29;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]      v3, rdy3;
  logic [3*PW-1:0] b3;
  logic            r3o, ov3;
  logic [PW-1:0]   ob3;
  logic [1:0]      ch3;

  logic [2:0]      vf, rdyf;
  logic [3*PW-1:0] bf;
  logic            rof, ovf;
  logic [PW-1:0]   obf;
  logic [1:0]      chf;

  logic [7:0]      v8, rdy8;
  logic [8*PW-1:0] b8;
  logic            ro8, ov8;
  logic [PW-1:0]   ob8;
  logic [2:0]      ch8;

  int ncmp = 0;
  int nerr = 0;

  typedef struct packed {
    logic [1:0]    ch;
    logic [PW-1:0] bits;
  } item_t;

  item_t      q[$];
  item_t      it;
  logic [2:0] acc;
  int         waitc[3];

  coreriscv_axi4_meta_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (v3),
    .io_in_ready  (rdy3),
    .io_in_bits   (b3),
    .io_out_valid (ov3),
    .io_out_ready (r3o),
    .io_out_bits  (ob3),
    .io_chosen    (ch3)
  );

  coreriscv_axi4_meta_arbiter #(.RR_MODE(0)) dutf (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (vf),
    .io_in_ready  (rdyf),
    .io_in_bits   (bf),
    .io_out_valid (ovf),
    .io_out_ready (rof),
    .io_out_bits  (obf),
    .io_chosen    (chf)
  );

  coreriscv_axi4_meta_arbiter #(.N_IN(8)) dut8 (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (v8),
    .io_in_ready  (rdy8),
    .io_in_bits   (b8),
    .io_out_valid (ov8),
    .io_out_ready (ro8),
    .io_out_bits  (ob8),
    .io_chosen    (ch8)
  );

  function automatic logic [PW-1:0] mk(
    logic [6:0]  idx,
    logic        way,
    logic [18:0] tag,
    logic [1:0]  coh
  );
    return {idx, way, tag, coh};
  endfunction

  function automatic logic [PW-1:0] pl(int i, int s);
    return mk(7'(i + 3 * s), 1'b1,
              19'(32'h100 * i + s), 2'(i));
  endfunction

  task automatic chk(
    string       tag,
    logic [63:0] obs,
    logic [63:0] exp
  );
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set3(int s);
    for (int i = 0; i < 3; i++) b3[i*PW +: PW] = pl(i, s);
  endtask

  initial begin
    logic [PW-1:0] pa;
    pa = mk(7'h15, 1'b1, 19'h1ABCD, 2'b10);
    reset = 1'b0;
    v3 = 3'b111; r3o = 1'b1; set3(0);
    vf = '0; rof = 1'b1;
    v8 = '0; ro8 = 1'b1;
    for (int i = 0; i < 3; i++) bf[i*PW +: PW] = pl(i, 0);
    for (int i = 0; i < 8; i++) b8[i*PW +: PW] = pl(i, 0);
    for (int i = 0; i < 3; i++) waitc[i] = 0;

    // Reset state
    #1;
    chk("rst_ov", ov3, 0);
    chk("rst_ob", ob3, 0);
    chk("rst_ch", ch3, 0);
    chk("rst_rdy", rdy3, 0);
    chk("rst_ptr", dut.ptr, 0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("first_rdy", rdy3, 3'b001);

    // Round-robin with all valid and full throughput
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_ch", ch3, k % 3);
      chk("rr_ov", ov3, 1);
      chk("rr_ob", ob3, pl(k % 3, 0));
    end

    // Hold an entry under back-pressure
    b3[0 +: PW] = pa;
    v3 = 3'b001;
    tick();
    chk("hold_load_ch", ch3, 0);
    chk("hold_load_ob", ob3, pa);
    r3o = 1'b0;
    v3 = 3'b110;
    set3(1);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stall_rdy", rdy3, 0);
      tick();
      chk("stall_ob", ob3, pa);
      chk("stall_ch", ch3, 0);
      chk("stall_ov", ov3, 1);
    end
    r3o = 1'b1;
    #1;
    chk("unstall_rdy", rdy3, 3'b010);
    tick();
    chk("unstall_ch", ch3, 1);
    chk("unstall_ob", ob3, pl(1, 1));

    // Asynchronous reset with a held entry
    r3o = 1'b0;
    v3 = 3'b111;
    #1;
    chk("pre_rst_ptr", dut.ptr, 2);
    chk("pre_rst_ov", ov3, 1);
    reset = 1'b0;
    #1;
    chk("arst_ov", ov3, 0);
    chk("arst_ob", ob3, 0);
    chk("arst_ch", ch3, 0);
    chk("arst_ptr", dut.ptr, 0);
    chk("arst_rdy", rdy3, 0);
    tick();
    reset = 1'b1;
    v3 = 3'b100;
    r3o = 1'b1;
    #1;
    chk("post_rst_rdy", rdy3, 3'b100);
    tick();
    chk("post_rst_ch", ch3, 2);
    chk("post_rst_ob", ob3, pl(2, 1));
    v3 = '0;
    tick();
    chk("deq_ov", ov3, 0);

    // Fixed priority
    vf = 3'b110;
    #1;
    chk("fix_rdy_a", rdyf, 3'b010);
    tick();
    chk("fix_ch_a", chf, 1);
    chk("fix_ob_a", obf, pl(1, 0));
    vf = 3'b111;
    #1;
    chk("fix_rdy_b", rdyf, 3'b001);
    tick();
    chk("fix_ch_b", chf, 0);
    vf = 3'b101;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fix_starve", chf, 0);
    end
    chk("fix_ptr", dutf.ptr, 0);
    vf = '0;

    // Eight requesters, wrap search from ptr 7
    v8 = 8'h40;
    tick();
    chk("n8_ch6", ch8, 6);
    chk("n8_ptr7", dut8.ptr, 7);
    v8 = 8'h08;
    #1;
    chk("n8_rdy", rdy8, 8'h08);
    tick();
    chk("n8_ch3", ch8, 3);
    chk("n8_ob3", ob8, pl(3, 0));
    chk("n8_ptr4", dut8.ptr, 4);
    v8 = 8'h18;
    tick();
    chk("n8_ch4", ch8, 4);
    v8 = '0;
    tick();

    // Random valid/ready with an in-order scoreboard
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!v3[i] && $urandom_range(0, 1) == 1) begin
          v3[i] = 1'b1;
          b3[i*PW +: PW] = pl(i, c);
        end
      end
      r3o = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      chk("onehot_rdy", $onehot0(rdy3), 1);
      if (ov3 && r3o) begin
        chk("sb_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          it = q.pop_front();
          chk("sb_ch", ch3, it.ch);
          chk("sb_bits", ob3, it.bits);
        end
      end
      acc = v3 & rdy3;
      for (int i = 0; i < 3; i++) begin
        if (acc[i]) begin
          it.ch = 2'(i);
          it.bits = b3[i*PW +: PW];
          q.push_back(it);
          chk("fair_wait", waitc[i] <= 3, 1);
          waitc[i] = 0;
        end else if (v3[i] && acc != 0) begin
          waitc[i]++;
        end
      end
      @(posedge clk);
      #1;
      v3 = v3 & ~acc;
    end

    // Drain
    v3 = '0;
    r3o = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ov3) begin
        chk("drain_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          it = q.pop_front();
          chk("drain_ch", ch3, it.ch);
          chk("drain_bits", ob3, it.bits);
        end
      end
      tick();
    end
    chk("sb_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
